// File: rtl/ifid_fetch_pkg.sv
// Constants shared by the fetch stage, decoder and hazard unit of the 8-bit RISC pipeline.
package ifid_fetch_pkg;

    localparam logic [7:0]  RESET_PC    = 8'h00;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;

endpackage

// File: rtl/ifid_fetch_ifid_reg.sv
// IF/ID pipeline register: load, hold (stall) or flush to a bubble, with asynchronous reset.
module ifid_reg #(
    parameter int                 ADDR_W    = 8,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            pc    <= pc_in;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (!hold) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/ifid_fetch.sv
// Instruction-fetch stage: PC, RUN/HALT control and the IF/ID register feeding decode.
module ifid_fetch #(
    parameter int                 ADDR_W      = 8,
    parameter int                 INSTR_W     = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC    = ifid_fetch_pkg::RESET_PC,
    parameter logic [3:0]         HALT_OPCODE = ifid_fetch_pkg::HALT_OPCODE,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = ifid_fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc_ifid_output,
    output logic [INSTR_W-1:0] instruction_ifid_output,
    output logic               valid_ifid_output,
    output logic               halted
);

    import ifid_fetch_pkg::*;

    logic              state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, ifid_pc_in;
    logic              ifid_hold, ifid_flush;
    logic              halt_fetched;

    assign halt_fetched = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);

    // Priority: branch_taken > stall > HALT > normal; stall is ignored once halted.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_pc_in = pc;
        if (branch_taken) begin
            pc_next    = branch_target;
            state_next = STATE_RUN;
            ifid_flush = 1'b1;
            ifid_pc_in = '0;
        end else if (state == STATE_HALT) begin
            ifid_flush = 1'b1;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else if (halt_fetched) begin
            state_next = STATE_HALT;
        end else begin
            pc_next = pc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= STATE_RUN;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    ifid_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (ifid_hold),
        .flush    (ifid_flush),
        .pc_in    (ifid_pc_in),
        .instr_in (imem_data),
        .pc       (pc_ifid_output),
        .instr    (instruction_ifid_output),
        .valid    (valid_ifid_output)
    );

    assign imem_addr = pc;
    assign halted    = (state == STATE_HALT);

endmodule

// File: doc/ifid_fetch.md
Name: ifid_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 8-bit RISC pipeline. It owns the PC and drives the instruction-memory address. It latches the fetched 16-bit instruction and its PC into the IF/ID register that feeds decode and, through decode, the ID/EX register. It honours load-use stalls and EX-stage branch redirects, and it freezes fetch when a HALT opcode is fetched.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- HALT_OPCODE, 4'hF, value of instruction[15:12] that halts fetch
- NOP_INSTR, 16'h0000, bubble instruction injected on flush/halt

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  load-use hazard: hold PC and IF/ID contents
- branch_taken  input  1  EX-stage redirect: flush IF/ID, load PC from branch_target
- branch_target  input  ADDR_W  redirect address
- imem_data  input  INSTR_W  combinational instruction-memory read data for imem_addr
- imem_addr  output  ADDR_W  current PC, driven straight from the PC register
- pc_ifid_output  output  ADDR_W  PC of the instruction held in IF/ID
- instruction_ifid_output  output  INSTR_W  instruction held in IF/ID
- valid_ifid_output  output  1  IF/ID holds a real instruction (0 = bubble)
- halted  output  1  fetch is frozen in HALT state

Behaviour:
- Reset (asynchronous, rst=1; takes effect immediately, not at the next edge):
  - PC=RESET_PC, state=RUN
  - pc_ifid_output=0, instruction_ifid_output=NOP_INSTR, valid_ifid_output=0, halted=0
- Reset asserted mid-operation discards everything in flight. First fetch after rst falls is from RESET_PC on the next rising edge.
- Two-state FSM: RUN, HALT. halted = (state==HALT).
- Per-edge priority: branch_taken > stall > HALT > normal.
- Normal (RUN, no stall, no branch):
  - IF/ID <= {PC, imem_data, valid=1}
  - PC <= PC+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00)
  - Fetch-to-IF/ID latency is 1 cycle.
- HALT detect: in RUN with no stall and no branch, if imem_data[15:12]==HALT_OPCODE:
  - the HALT instruction is latched into IF/ID with valid=1
  - PC is held (not incremented)
  - state <= HALT
- HALT state, no branch:
  - PC held
  - IF/ID <= {PC, NOP_INSTR, valid=0} every cycle, so the pipeline drains
  - stall has no effect
- branch_taken (either state):
  - PC <= branch_target
  - IF/ID <= {0, NOP_INSTR, valid=0}
  - state <= RUN
  - A branch cancels a younger HALT, because the HALT sits behind the branch in the pipe.
- stall (RUN, no branch):
  - PC, IF/ID and state all held unchanged
  - imem_addr stays stable
- Simultaneous stall and branch_taken: the branch wins; the flush and redirect happen.
- Branch to a HALT address: the redirect happens first. The HALT is detected on the following fetch edge.
- No combinational path from any input to any output. imem_addr, halted and all IF/ID outputs are registered.

Decomposition:
- Shared package constants:
  - HALT_OPCODE, NOP_INSTR, RESET_PC
  - FSM state encoding: RUN=1'b0, HALT=1'b1
  - These are shared with the decoder and hazard unit.
- Sub-module: ifid_reg. This is the IF/ID register holding pc/instruction/valid. It has hold (stall) and flush (load NOP, valid=0) controls and the asynchronous reset.
- PC logic and the FSM stay in the top level.

Test Plan:
- Reset then free-run with imem returning 16'h1200+addr:
  - Cycle 1 after release: IF/ID = {00, 16'h1200, 1}.
  - Cycle 3: IF/ID = {02, 16'h1202, 1}; imem_addr=03.
- Stall for 2 cycles at PC=05:
  - imem_addr holds 05 and IF/ID holds {04, 16'h1204, 1} through both cycles.
  - Resumes {05, 16'h1205} one cycle after stall drops.
- branch_taken=1, stall=1, branch_target=8'h40 together:
  - Next edge: imem_addr=40, valid_ifid_output=0, instruction=0000.
  - Following edge: IF/ID = {40, imem_data, 1}.
- Fetch 16'hF000 at PC=10:
  - IF/ID = {10, F000, 1}; halted=1; imem_addr stays 10.
  - Subsequent cycles: valid=0, NOP_INSTR.
  - A branch to 8'h20 in HALT returns to RUN with halted=0 and imem_addr=20.
- PC wrap: start at 8'hFE:
  - Fetches FE, FF, then 00; no stall, no spurious bubble.
- Assert rst asynchronously mid-cycle during a branch:
  - Outputs go to reset values before the next clock edge.
  - After release, the first fetch is from 00.
